bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port start, input, 1, request to convert the current digit inputs; sampled only in IDLE.
REQ-004 SHALL have port HUNDREDS, input, 4, BCD hundreds digit, legal range 0-9.
REQ-005 SHALL have port TENS, input, 4, BCD tens digit, legal range 0-9.
REQ-006 SHALL have port ONES, input, 4, BCD ones digit, legal range 0-9.
REQ-007 SHALL have port BIN, output, 10, full binary result, 0-999.
REQ-008 SHALL have port sum, output, 8, low 8 bits of BIN, for the existing 8-bit display path.
REQ-009 SHALL have port ovf, output, 1, result exceeds 255 (BIN[9:8] nonzero).
REQ-010 SHALL have port err, output, 1, a captured digit was greater than 9.
REQ-011 SHALL have port busy, output, 1, high in SHIFT and DONE states.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when BIN, sum, ovf and err are valid.

Function
REQ-013 SHALL implement three states: IDLE, SHIFT, DONE; encoding is free.
REQ-014 IDLE with start=1: capture {HUNDREDS,TENS,ONES} into a 12-bit BCD register, clear the 10-bit work register and the 4-bit iteration count, and go to SHIFT.
REQ-015 IDLE with start=1 and any captured digit >9: set err=1, force the result to 0, and go directly to DONE with no SHIFT cycles.
REQ-016 Each SHIFT cycle: shift the 22-bit {bcd,work} right by 1 (bcd LSB enters work MSB); then subtract 3 from each 4-bit BCD digit whose value is 8 or more; increment the count.
REQ-017 SHIFT SHALL run exactly 10 cycles; on the 10th cycle (count==9) go to DONE.
REQ-018 On entry to DONE: load BIN=work, sum=work[7:0], ovf=|work[9:8]; hold these outputs until the next DONE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 Latency for valid digits: done high in the 12th cycle counted from the cycle start is sampled, which is cycle 1.
REQ-021 Latency for invalid digits: done high in the 2nd cycle.
REQ-022 start while busy=1 SHALL be ignored; it is not queued.
REQ-023 start held high continuously SHALL trigger back-to-back conversions, with one IDLE cycle between done and the next capture.
REQ-024 Digit inputs SHALL NOT affect an in-progress conversion after capture.
REQ-025 err SHALL clear at the next valid capture; ovf SHALL be 0 whenever err=1.

Reset
REQ-026 reset=1 SHALL force IDLE and set BIN=0, sum=0, ovf=0, err=0, busy=0, done=0, count=0, and clear the BCD and work registers.
REQ-027 reset SHALL take priority over start and over any state transition.
REQ-028 reset asserted mid-SHIFT SHALL abort the conversion with no done pulse; the next start begins a fresh conversion.

Verification
REQ-029 H=2,T=5,O=5, start pulse -> done in cycle 12; BIN=255, sum=0xFF, ovf=0, err=0.
REQ-030 H=9,T=9,O=9 -> BIN=999 (0x3E7), sum=0xE7, ovf=1; then H=0,T=0,O=0 -> BIN=0, ovf=0.
REQ-031 H=1,T=0xA,O=3 -> done in cycle 2, err=1, BIN=0, sum=0, ovf=0; then a valid 1,2,8 -> BIN=128, err=0.
REQ-032 start=1 held, digits changed during busy -> the first result reflects the captured digits; the second conversion starts one cycle after done.
REQ-033 reset asserted in SHIFT cycle 5 -> no done pulse; all outputs 0 and busy=0 on the next cycle; a following start with 0,4,2 -> BIN=42.
REQ-034 Exhaustive sweep of 000-999 -> BIN equals the decimal value each time; ovf=1 exactly for values 256-999.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Three-digit BCD to 10-bit binary converter using the iterative shift-right / subtract-3 algorithm.
// One shift per clock cycle; results are registered and held until the next conversion completes.
module bcd_to_binary (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] HUNDREDS,
    input  logic [3:0] TENS,
    input  logic [3:0] ONES,
    output logic [9:0] BIN,
    output logic [7:0] sum,
    output logic       ovf,
    output logic       err,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  r_state;
    logic [11:0] r_bcd;
    logic [9:0]  r_work;
    logic [3:0]  r_count;
    logic [9:0]  r_bin;
    logic [7:0]  r_sum;
    logic        r_ovf;
    logic        r_err;
    logic        r_busy;
    logic        r_done;

    logic [11:0] w_bcd_shifted;
    logic [11:0] w_bcd_next;
    logic [9:0]  w_work_next;
    logic        w_digit_bad;

    // A digit that reached 8+ after the shift was >=16 before halving; remove the excess 6/2.
    function automatic logic [3:0] adj_digit(input logic [3:0] d);
        if (d >= 4'd8) begin
            return d - 4'd3;
        end else begin
            return d;
        end
    endfunction

    // Datapath for one shift step and input digit legality.
    always_comb begin
        w_bcd_shifted = {1'b0, r_bcd[11:1]};
        w_work_next   = {r_bcd[0], r_work[9:1]};
        w_bcd_next    = {adj_digit(w_bcd_shifted[11:8]),
                         adj_digit(w_bcd_shifted[7:4]),
                         adj_digit(w_bcd_shifted[3:0])};
        w_digit_bad   = (HUNDREDS > 4'd9) || (TENS > 4'd9) || (ONES > 4'd9);
    end

    // Control FSM, conversion registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bcd   <= 12'd0;
            r_work  <= 10'd0;
            r_count <= 4'd0;
            r_bin   <= 10'd0;
            r_sum   <= 8'd0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bcd   <= {HUNDREDS, TENS, ONES};
                        r_work  <= 10'd0;
                        r_count <= 4'd0;
                        r_busy  <= 1'b1;
                        if (w_digit_bad) begin
                            r_err   <= 1'b1;
                            r_bin   <= 10'd0;
                            r_sum   <= 8'd0;
                            r_ovf   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_SHIFT;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= w_bcd_next;
                    r_work  <= w_work_next;
                    r_count <= r_count + 4'd1;
                    if (r_count == 4'd9) begin
                        r_bin   <= w_work_next;
                        r_sum   <= w_work_next[7:0];
                        r_ovf   <= |w_work_next[9:8];
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign BIN  = r_bin;
    assign sum  = r_sum;
    assign ovf  = r_ovf;
    assign err  = r_err;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Randomized self-checking bench for bcd_to_binary against an arithmetic reference model.
module tb_bcd_to_binary;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] HUNDREDS;
    logic [3:0] TENS;
    logic [3:0] ONES;
    logic [9:0] BIN;
    logic [7:0] sum;
    logic       ovf;
    logic       err;
    logic       busy;
    logic       done;

    int n_vectors     = 0;
    int n_miscompares = 0;

    bcd_to_binary dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .HUNDREDS (HUNDREDS),
        .TENS     (TENS),
        .ONES     (ONES),
        .BIN      (BIN),
        .sum      (sum),
        .ovf      (ovf),
        .err      (err),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vectors++;
        if (obs != exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: decimal value of legal digits, else 0.
    function automatic bit digits_ok(input int h, input int t, input int o);
        return (h <= 9) && (t <= 9) && (o <= 9);
    endfunction

    function automatic int ref_value(input int h, input int t, input int o);
        return digits_ok(h, t, o) ? (h * 100 + t * 10 + o) : 0;
    endfunction

    task automatic check_result(input string tag, input int h, input int t, input int o);
        int v;
        v = ref_value(h, t, o);
        check({tag, ".BIN"}, int'(BIN), v);
        check({tag, ".sum"}, int'(sum), v % 256);
        check({tag, ".ovf"}, int'(ovf), (v > 255) ? 1 : 0);
        check({tag, ".err"}, int'(err), digits_ok(h, t, o) ? 0 : 1);
        check({tag, ".busy"}, int'(busy), 1);
    endtask

    // Pulse start with the given digits; optionally disturb digits and start while busy.
    task automatic run_conv(input string tag, input int h, input int t, input int o, input bit scramble);
        int lat;
        lat = 0;
        HUNDREDS = 4'(h);
        TENS     = 4'(t);
        ONES     = 4'(o);
        start    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k + 1;
                break;
            end
            start = 1'b0;
            if (scramble) begin
                HUNDREDS = 4'($urandom_range(15, 0));
                TENS     = 4'($urandom_range(15, 0));
                ONES     = 4'($urandom_range(15, 0));
                start    = 1'($urandom_range(1, 0));
            end
        end
        start = 1'b0;
        check({tag, ".latency"}, lat, digits_ok(h, t, o) ? 12 : 2);
        check_result(tag, h, t, o);
        @(negedge clk);
        check({tag, ".done_pulse"}, int'(done), 0);
        check({tag, ".idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        int h2, t2, o2, lat;
        reset    = 1'b1;
        start    = 1'b0;
        HUNDREDS = 4'd0;
        TENS     = 4'd0;
        ONES     = 4'd0;
        repeat (3) @(negedge clk);
        check("rst.BIN", int'(BIN), 0);
        check("rst.sum", int'(sum), 0);
        check("rst.ovf", int'(ovf), 0);
        check("rst.err", int'(err), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        run_conv("d255", 2, 5, 5, 1'b0);
        run_conv("d999", 9, 9, 9, 1'b0);
        run_conv("d000", 0, 0, 0, 1'b0);
        run_conv("bad1A3", 1, 10, 3, 1'b0);
        run_conv("d128", 1, 2, 8, 1'b0);
        run_conv("d256", 2, 5, 6, 1'b1);
        run_conv("badFFF", 15, 15, 15, 1'b1);

        // Start held high: back-to-back conversions with one IDLE cycle between.
        HUNDREDS = 4'd3; TENS = 4'd1; ONES = 4'd7;
        start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k + 1;
                break;
            end
            HUNDREDS = 4'($urandom_range(15, 0));
            TENS     = 4'($urandom_range(15, 0));
            ONES     = 4'($urandom_range(15, 0));
        end
        check("b2b1.latency", lat, 12);
        check_result("b2b1", 3, 1, 7);
        h2 = int'($urandom_range(9, 0));
        t2 = int'($urandom_range(9, 0));
        o2 = int'($urandom_range(9, 0));
        HUNDREDS = 4'(h2); TENS = 4'(t2); ONES = 4'(o2);
        @(negedge clk);
        check("b2b.gap_busy", int'(busy), 0);
        check("b2b.gap_done", int'(done), 0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("b2b.restart_busy", int'(busy), 1);
            end
            if (done) begin
                lat = k + 1;
                break;
            end
            HUNDREDS = 4'($urandom_range(15, 0));
            TENS     = 4'($urandom_range(15, 0));
            ONES     = 4'($urandom_range(15, 0));
        end
        start = 1'b0;
        check("b2b2.latency", lat, 12);
        check_result("b2b2", h2, t2, o2);
        @(negedge clk);

        // Reset during the fifth SHIFT cycle aborts without a done pulse.
        run_conv("pre_abort", 9, 9, 9, 1'b0);
        HUNDREDS = 4'd5; TENS = 4'd5; ONES = 4'd5;
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("abort.no_done", int'(done), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.BIN", int'(BIN), 0);
        check("abort.sum", int'(sum), 0);
        check("abort.ovf", int'(ovf), 0);
        check("abort.err", int'(err), 0);
        check("abort.busy", int'(busy), 0);
        check("abort.done", int'(done), 0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("abort.quiet", int'(done), 0);
        end
        run_conv("d042", 0, 4, 2, 1'b0);

        // Random digits including illegal codes, with disturbances while busy.
        for (int i = 0; i < 150; i++) begin
            run_conv("rand", int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                     int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
        end

        // Exhaustive sweep of legal values.
        for (int v = 0; v < 1000; v++) begin
            run_conv("sweep", v / 100, (v / 10) % 10, v % 10, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
